// File: rtl/uart_rx.sv
// UART receiver, 8N1 with 16x oversampling and a one-cycle rx_done_tick per frame.
// Defining UART_RX_PARITY_EN adds an even-parity bit (8E1) and drives parity_err.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 54
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            rx,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            parity_err
);
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int CW = (DVSR > 1) ? $clog2(DVSR) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state;
    logic            rx_meta;
    logic            rx_s;
    logic [CW-1:0]   tick_cnt;
    logic            s_tick;
    logic [3:0]      s_reg;
    logic [NW-1:0]   n_reg;
    logic [DBIT-1:0] b_reg;
`ifdef UART_RX_PARITY_EN
    logic            par_bit;
`endif

    // rx is asynchronous; everything downstream looks only at rx_s.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign s_tick = (tick_cnt == CW'(DVSR - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (s_tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            s_reg        <= '0;
            n_reg        <= '0;
            b_reg        <= '0;
            rx_data      <= '0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit      <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s_reg <= '0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_reg == 4'd7) begin
                            // Line back high at mid start bit: treat as a glitch.
                            if (!rx_s) begin
                                state <= DATA;
                                s_reg <= '0;
                                n_reg <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s_reg <= s_reg + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_reg == 4'd15) begin
                            s_reg <= '0;
                            b_reg <= {rx_s, b_reg[DBIT-1:1]};
                            if (n_reg == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                n_reg <= n_reg + NW'(1);
                            end
                        end else begin
                            s_reg <= s_reg + 4'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (s_tick) begin
                        if (s_reg == 4'd15) begin
                            s_reg   <= '0;
                            par_bit <= rx_s;
                            state   <= STOP;
                        end else begin
                            s_reg <= s_reg + 4'd1;
                        end
                    end
                end
`endif
                STOP: begin
                    if (s_tick) begin
                        // Leaving at mid stop bit lets a back-to-back start edge be caught.
                        if (s_reg == 4'(SB_TICK - 1)) begin
                            state        <= IDLE;
                            rx_done_tick <= 1'b1;
                            rx_data      <= b_reg;
                            frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err   <= ^b_reg ^ par_bit;
`endif
                        end else begin
                            s_reg <= s_reg + 4'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame table plus hand sequences for glitch and mid-frame reset.
module tb_uart_rx;
    localparam int DVSR     = 54;
    localparam int BIT_CLKS = 16 * DVSR;
`ifdef UART_RX_PARITY_EN
    localparam int   LAT_NOM = 8208 + BIT_CLKS;
    localparam logic PAR_EN  = 1'b1;
    localparam int   NV      = 5;
`else
    localparam int   LAT_NOM = 8208;
    localparam logic PAR_EN  = 1'b0;
    localparam int   NV      = 4;
`endif
    localparam int LAT_TOL = DVSR + 4;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       par_flip;
        int         gap_bits;
        logic [7:0] exp_data;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_done_tick;
    logic       frame_err;
    logic       parity_err;

    vec_t       vecs[NV];
    logic [9:0] exp_q[$];
    longint     start_q[$];
    longint     cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         tick_count = 0;
    logic       prev_tick = 1'b0;

    uart_rx #(.DBIT(8), .SB_TICK(16), .DVSR(DVSR)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx(rx),
        .rx_data(rx_data),
        .rx_done_tick(rx_done_tick),
        .frame_err(frame_err),
        .parity_err(parity_err)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive rx at v for clks cycles; always returns 1 time unit after a rising edge.
    task automatic hold(input logic v, input int clks);
        rx = v;
        repeat (clks) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_flip,
                              input int gap_bits, input logic [7:0] exp_data,
                              input logic exp_ferr, input logic exp_perr);
        exp_q.push_back({exp_data, exp_ferr, exp_perr});
        start_q.push_back(cyc);
        hold(1'b0, BIT_CLKS);
        for (int i = 0; i < 8; i++) hold(data[i], BIT_CLKS);
        if (PAR_EN) hold(^data ^ par_flip, BIT_CLKS);
        if (stop_bit) begin
            hold(1'b1, BIT_CLKS);
        end else begin
            // Low only over the sampling window, so the line is high again before a restart check.
            hold(1'b0, 600);
            hold(1'b1, BIT_CLKS - 600);
        end
        if (gap_bits > 0) hold(1'b1, gap_bits * BIT_CLKS);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3 * BIT_CLKS) begin
            @(posedge clk);
            n++;
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d frames still pending, expected 0", exp_q.size());
            exp_q.delete();
            start_q.delete();
        end
    endtask

    // Scoreboard: every rx_done_tick pops one expected frame.
    always @(negedge clk) begin
        logic [9:0] e;
        longint     lat;
        if (rx_done_tick) begin
            tick_count++;
            check("no_consecutive_tick", {31'b0, prev_tick}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_tick: rx_done_tick with rx_data=0x%0h, expected no frame", rx_data);
            end else begin
                e   = exp_q.pop_front();
                lat = cyc - start_q.pop_front();
                check("rx_data", {24'b0, rx_data}, {24'b0, e[9:2]});
                check("frame_err", {31'b0, frame_err}, {31'b0, e[1]});
                check("parity_err", {31'b0, parity_err}, {31'b0, e[0]});
                n_checks++;
                if (lat < LAT_NOM - LAT_TOL || lat > LAT_NOM + LAT_TOL) begin
                    n_fail++;
                    $display("FAIL latency: got %0d clk, expected %0d +/- %0d", lat, LAT_NOM, LAT_TOL);
                end
            end
        end
        prev_tick = rx_done_tick;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        vecs[0] = '{8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'hFF, 1'b1, 1'b0, 1, 8'hFF, 1'b0, 1'b0};
        vecs[2] = '{8'hA5, 1'b0, 1'b0, 1, 8'hA5, 1'b1, 1'b0};
        vecs[3] = '{8'h5A, 1'b1, 1'b0, 1, 8'h5A, 1'b0, 1'b0};
`ifdef UART_RX_PARITY_EN
        vecs[4] = '{8'hAA, 1'b1, 1'b1, 1, 8'hAA, 1'b0, 1'b1};
`endif

        // Reset state
        reset_n = 1'b0;
        rx      = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_rx_data", {24'b0, rx_data}, 32'd0);
        check("reset_tick", {31'b0, rx_done_tick}, 32'd0);
        check("reset_frame_err", {31'b0, frame_err}, 32'd0);
        check("reset_parity_err", {31'b0, parity_err}, 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        hold(1'b1, 100);

        // Single 0xAA frame, then the byte must be held
        t0 = tick_count;
        send_frame(8'hAA, 1'b1, 1'b0, 0, 8'hAA, 1'b0, 1'b0);
        wait_drain();
        hold(1'b1, 2000);
        check("hold_rx_data", {24'b0, rx_data}, 32'h0000_00AA);
        check("single_pulse", tick_count - t0, 32'd1);

        // Table: back-to-back 00/FF, stop-bit error then clean frame, parity error
        for (int i = 0; i < NV; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].par_flip, vecs[i].gap_bits,
                       vecs[i].exp_data, vecs[i].exp_ferr, vecs[i].exp_perr);
        end
        wait_drain();

        // Start-bit glitch must be rejected, then a normal frame follows
        t0 = tick_count;
        hold(1'b0, 4 * DVSR);
        hold(1'b1, 12000 - 4 * DVSR);
        check("glitch_no_tick", tick_count - t0, 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0, 0, 8'h3C, 1'b0, 1'b0);
        wait_drain();

        // Reset during data bit 3 of 0x81
        hold(1'b0, BIT_CLKS);
        hold(1'b1, BIT_CLKS);
        hold(1'b0, 2 * BIT_CLKS);
        hold(1'b0, 400);
        t0 = tick_count;
        reset_n = 1'b0;
        rx      = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("abort_rx_data", {24'b0, rx_data}, 32'd0);
        check("abort_frame_err", {31'b0, frame_err}, 32'd0);
        check("abort_parity_err", {31'b0, parity_err}, 32'd0);
        hold(1'b1, BIT_CLKS);
        check("abort_no_tick", tick_count - t0, 32'd0);
        send_frame(8'h81, 1'b1, 1'b0, 0, 8'h81, 1'b0, 1'b0);
        wait_drain();
        hold(1'b1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
